// File: rtl/updn_cmd_pkg.sv
// Shared definitions for the up/down command generator.
//   state_e : FSM states of updn_cmd_gen
//   cmd_e   : decoded button command (NONE / UP / DOWN)
//   DEF_*   : default timing parameters
package updn_cmd_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_REPEAT_DELAY    = 16;
    localparam int unsigned DEF_REPEAT_PERIOD   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_FIRE,
        ST_HOLD_WAIT,
        ST_REPEAT,
        ST_DEB_RELEASE
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DOWN
    } cmd_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Both buttons equal (idle or chorded) means no command.
    function automatic cmd_e decode_cmd(input logic up, input logic dn);
        if (up && !dn) return CMD_UP;
        if (dn && !up) return CMD_DOWN;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for an asynchronous input.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i edges of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/updn_cmd_gen.sv
// Turns two raw bouncing buttons into step pulses for an up/down counter,
// with debounce, single fire per press and auto-repeat while held.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_btn_up   : raw "count up" button
//   i_btn_down : raw "count down" button
//   o_en       : one-cycle step pulse
//   o_up_down  : direction (1 = up), changes only with o_en
//   o_busy     : FSM not idle
module updn_cmd_gen
    import updn_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_up,
    input  logic i_btn_down,
    output logic o_en,
    output logic o_up_down,
    output logic o_busy
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_CYCLES);
    // Release counts the cycle being evaluated, hence one less.
    localparam logic [CNT_W-1:0] REL_N = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_N  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_N  = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    logic   up_s;
    logic   dn_s;
    cmd_e   cmd;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    cmd_e             cmd_q,   cmd_d;
    logic             en_q,    en_d;
    logic             dir_q,   dir_d;

    sync_2ff u_sync_up (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (i_btn_up),
        .q_o   (up_s)
    );

    sync_2ff u_sync_dn (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (i_btn_down),
        .q_o   (dn_s)
    );

    assign cmd = decode_cmd(up_s, dn_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= CMD_NONE;
            en_q    <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
        end
    end

    // Pulse and direction are registered on the edge entering the pulse
    // cycle, so they are visible exactly during FIRE / the repeat tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        en_d    = 1'b0;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd != CMD_NONE) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = ONE;
                    cmd_d   = cmd;
                end
            end
            ST_DEB_PRESS: begin
                if (cmd != cmd_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_N) begin
                    state_d = ST_FIRE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    dir_d   = (cmd_q == CMD_UP);
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_FIRE: begin
                state_d = ST_HOLD_WAIT;
                cnt_d   = ONE;
            end
            ST_HOLD_WAIT, ST_REPEAT: begin
                if (cmd != cmd_q) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = (cmd == CMD_NONE) ? ONE : '0;
                end else if (cnt_q >= ((state_q == ST_HOLD_WAIT) ? RD_N : RP_N)) begin
                    state_d = ST_REPEAT;
                    cnt_d   = ONE;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_DEB_RELEASE: begin
                if (cmd != CMD_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q >= REL_N) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    cmd_d   = CMD_NONE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_en      = en_q;
    assign o_up_down = dir_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_updn_cmd_gen.sv
`timescale 1ns/1ps
module tb_updn_cmd_gen;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst;
    logic up;
    logic dn;
    logic en;
    logic ud;
    logic busy;

    updn_cmd_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_up   (up),
        .i_btn_down (dn),
        .o_en       (en),
        .o_up_down  (ud),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 3-bit up/down counter fed by the DUT, standing in for mod_n_cntr
    logic [2:0] tb_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)     tb_cnt <= '0;
        else if (en) tb_cnt <= ud ? tb_cnt + 3'd1 : tb_cnt - 3'd1;
    end

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_dir = 1'b1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    exp_t mon_e;
    logic prev_en  = 1'b0;
    logic last_dir = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            prev_en  = 1'b0;
            last_dir = 1'b1;
        end else begin
            if (en) begin
                chk("en_back_to_back", int'(prev_en), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse_cycle", cyc, -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    chk("pulse_dir", int'(ud), int'(mon_e.dir));
                end
                last_dir = ud;
            end else begin
                chk("dir_held", int'(ud), int'(last_dir));
            end
            prev_en = en;
        end
    end

    task automatic drive(input logic dir, input logic v);
        if (dir) up = v;
        else     dn = v;
    endtask

    // Reference: pulse at 2+D after the stable rise, then at 3+D+RD+k*RP,
    // as long as the synchronized button is still held at that edge.
    task automatic push_pulses(input int c0, input int hold, input logic dir);
        exp_t e;
        e.dir = dir;
        if (2 + D <= hold + 1) begin
            e.cyc = c0 + 1 + 2 + D;
            sb.push_back(e);
            exp_dir = dir;
        end
        for (int t = 3 + D + RD; t <= hold + 1; t += RP) begin
            e.cyc = c0 + 1 + t;
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge where the button is released.
    task automatic press(input logic dir, input int hold, input bit bounce, output int c0);
        if (bounce) begin
            for (int i = 0; i < 4; i++) begin
                drive(dir, (i % 2) == 0);
                @(negedge clk);
            end
        end
        drive(dir, 1'b1);
        c0 = cyc;
        push_pulses(c0, hold, dir);
        repeat (hold) @(negedge clk);
        drive(dir, 1'b0);
    endtask

    task automatic drain(input int gap, input string name);
        repeat (gap) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic d;
        int h;
        bit b;

        rst = 1'b1;
        up  = 1'b0;
        dn  = 1'b0;
        #1;
        chk("reset_en", int'(en), 0);
        chk("reset_ud", int'(ud), 1);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Counter integration: 5 up, 2 down -> 3
        for (int i = 0; i < 7; i++) begin
            press((i < 5), 10, 1'b0, c0);
            repeat (10) @(negedge clk);
        end
        drain(5, "sb_counter");
        chk("counter_value", int'(tb_cnt), 3);

        // Clean up press held 10 cycles; busy drops 4 cycles after sync release
        press(1'b1, 10, 1'b0, c0);
        repeat (5) @(negedge clk);
        chk("busy_before_idle", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_release", int'(busy), 0);
        drain(10, "sb_clean_up");

        // Bouncing up press
        press(1'b1, 12, 1'b1, c0);
        drain(15, "sb_bounce");

        // Down held 60 cycles: pulses at 6, 23, 31, ...
        press(1'b0, 60, 1'b0, c0);
        chk("down_dir", int'(ud), 0);
        drain(15, "sb_down_hold");

        // Both pressed together: nothing happens
        up = 1'b1;
        dn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("both_busy", int'(busy), 0);
        end
        up = 1'b0;
        dn = 1'b0;
        drain(10, "sb_both");
        chk("both_dir_kept", int'(ud), int'(exp_dir));

        // Reversal while held: only the first command fires
        up = 1'b1;
        c0 = cyc;
        push_pulses(c0, 10, 1'b1);
        repeat (10) @(negedge clk);
        up = 1'b0;
        dn = 1'b1;
        repeat (20) @(negedge clk);
        chk("reversal_in_release", int'(busy), 1);
        dn = 1'b0;
        drain(12, "sb_reversal");
        chk("reversal_dir", int'(ud), 1);

        // Reset during REPEAT with down held
        dn = 1'b1;
        c0 = cyc;
        push_pulses(c0, 35, 1'b0);
        repeat (36) @(negedge clk);
        chk("pre_reset_ud", int'(ud), 0);
        chk("pre_reset_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_en", int'(en), 0);
        chk("async_reset_ud", int'(ud), 1);
        chk("async_reset_busy", int'(busy), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        c0 = cyc;
        push_pulses(c0, 12, 1'b0);
        repeat (12) @(negedge clk);
        dn = 1'b0;
        drain(12, "sb_after_reset");

        // Randomized presses
        for (int i = 0; i < 8; i++) begin
            d = 1'($urandom_range(0, 1));
            h = int'($urandom_range(4, 60));
            b = 1'($urandom_range(0, 1));
            press(d, h, b, c0);
            repeat ($urandom_range(8, 14)) @(negedge clk);
        end
        drain(5, "sb_random");
        chk("random_dir", int'(ud), int'(exp_dir));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
